// File: rtl/seg_scan_decoder.sv
// Recovers four hex digits from a multiplexed active-low 7-segment scan bus.
// Optional macro SEG_SCAN_DECODER_SYNC_EN adds a 2-flop input synchronizer on an/seg.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  dp_out,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam int unsigned SMP_W = 12;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic {S_WAIT = 1'b0, S_PUBLISH = 1'b1} state_t;

  // Returns {err, nibble}; unknown glyphs decode to 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h18: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h06: decode = 5'h0E;
      7'h0E: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  logic [SMP_W-1:0] smp_in;

`ifdef SEG_SCAN_DECODER_SYNC_EN
  logic [SMP_W-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {an, seg};
      sync2 <= sync1;
    end
  end

  assign smp_in = sync2;
`else
  assign smp_in = {an, seg};
`endif

  logic [SMP_W-1:0] smp_q;
  logic [CNT_W-1:0] run_cnt, run_cnt_next;
  logic [15:0]      sh_dig, sh_dig_next;
  logic [3:0]       sh_dp, sh_dp_next;
  logic [3:0]       sh_err, sh_err_next;
  logic [3:0]       mask, mask_next;
  logic [15:0]      digits_next;
  logic [3:0]       dp_out_next, digit_err_next;
  logic             frame_valid_next, stale_next;
  logic [TMR_W-1:0] timer, timer_next;
  state_t           state, state_next;
  logic             same_c, onehot_c, cap_c, publish_c;
  logic [3:0]       sel_c, mask_or_c;
  logic [4:0]       dec_c;

  // Next-state: stability tracking, capture into shadow, frame FSM, staleness timer.
  always_comb begin
    same_c           = (smp_in == smp_q);
    sel_c            = ~smp_q[11:8];
    onehot_c         = (smp_q[11:8] inside {4'b1110, 4'b1101, 4'b1011, 4'b0111});
    cap_c            = same_c && (run_cnt == CNT_PRE) && onehot_c;
    dec_c            = decode(smp_q[6:0]);
    run_cnt_next     = '0;
    sh_dig_next      = sh_dig;
    sh_dp_next       = sh_dp;
    sh_err_next      = sh_err;
    mask_or_c        = mask;
    publish_c        = 1'b0;
    mask_next        = mask;
    state_next       = state;
    digits_next      = digits;
    dp_out_next      = dp_out;
    digit_err_next   = digit_err;
    frame_valid_next = 1'b0;
    timer_next       = timer;
    stale_next       = 1'b0;

    if (same_c)
      run_cnt_next = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_W'(1);

    if (cap_c) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_c[i]) begin
          sh_dig_next[4*i +: 4] = dec_c[3:0];
          sh_err_next[i]        = dec_c[4];
          sh_dp_next[i]         = ~smp_q[7];
        end
      end
      mask_or_c = mask | sel_c;
    end

    publish_c = (mask_or_c == 4'hF);
    mask_next = publish_c ? 4'h0 : mask_or_c;

    // The mask is always empty in PUBLISH, so a capture there cannot complete a frame.
    case (state)
      S_WAIT:    if (publish_c) state_next = S_PUBLISH;
      S_PUBLISH: state_next = S_WAIT;
      default:   state_next = S_WAIT;
    endcase

    frame_valid_next = (state_next == S_PUBLISH);
    if (publish_c) begin
      digits_next    = sh_dig_next;
      dp_out_next    = sh_dp_next;
      digit_err_next = sh_err_next;
    end

    if (frame_valid_next)
      timer_next = '0;
    else if (timer != TMR_MAX)
      timer_next = timer + TMR_W'(1);
    stale_next = !frame_valid_next && (timer_next == TMR_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q       <= '1;
      run_cnt     <= '0;
      sh_dig      <= '0;
      sh_dp       <= '0;
      sh_err      <= '0;
      mask        <= '0;
      state       <= S_WAIT;
      digits      <= '0;
      dp_out      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      timer       <= '0;
      stale       <= 1'b0;
    end else begin
      smp_q       <= smp_in;
      run_cnt     <= run_cnt_next;
      sh_dig      <= sh_dig_next;
      sh_dp       <= sh_dp_next;
      sh_err      <= sh_err_next;
      mask        <= mask_next;
      state       <= state_next;
      digits      <= digits_next;
      dp_out      <= dp_out_next;
      digit_err   <= digit_err_next;
      frame_valid <= frame_valid_next;
      timer       <= timer_next;
      stale       <= stale_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: directed scans push expected frames, a monitor checks them.
module tb_seg_scan_decoder;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [15:0] digits;
  logic [3:0]  dp_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  int checks = 0;
  int fails  = 0;
  frame_t exp_q[$];
  frame_t last;

  seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .digits(digits),
    .dp_out(dp_out), .digit_err(digit_err), .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present {a,s} for n rising edges.
  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] err);
    frame_t f;
    f.d = d; f.dp = dp; f.err = err;
    exp_q.push_back(f);
  endtask

  // Monitor: every frame_valid must match the head of the queue; outputs hold otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      last = '0;
    end else if (frame_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", {16'd0, digits}, 32'hFFFF_FFFF);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        check("frame_digits", 32'(digits), 32'(e.d));
        check("frame_dp", 32'(dp_out), 32'(e.dp));
        check("frame_err", 32'(digit_err), 32'(e.err));
        check("stale_clr_on_frame", 32'(stale), 32'd0);
        last = e;
      end
    end else begin
      check("outputs_hold", 32'({digits, dp_out, digit_err}), 32'(last));
    end
  end

  initial begin
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 8'hFF;
    #12;
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_dp", 32'(dp_out), 32'd0);
    check("rst_err", 32'(digit_err), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_stale", 32'(stale), 32'd0);

    // Idle after reset: stale rises on the 16th edge.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1 check("stale_before_timeout", 32'(stale), 32'd0);
    @(posedge clk);
    #1 check("stale_at_timeout", 32'(stale), 32'd1);

    // Basic scan 1,2,3,4.
    push(16'h4321, 4'h0, 4'h0);
    hold(4'hE, 8'hF9, 4); hold(4'hD, 8'hA4, 4); hold(4'hB, 8'hB0, 4); hold(4'h7, 8'h99, 4);
    hold(4'hF, 8'hFF, 6);
    check("stale_cleared", 32'(stale), 32'd0);

    // Digit 2 held only 3 cycles: no frame until it is held long enough.
    hold(4'hE, 8'hF9, 4); hold(4'hD, 8'hA4, 4); hold(4'hB, 8'hB0, 3); hold(4'h7, 8'h99, 4);
    hold(4'hF, 8'hFF, 8);
    check("no_frame_short_hold", 32'(exp_q.size()), 32'd0);
    push(16'h4321, 4'h0, 4'h0);
    hold(4'hB, 8'hB0, 4);
    hold(4'hF, 8'hFF, 6);

    // All segments + dp lit on digit 0, blank (illegal) glyph on digit 1.
    push(16'h4308, 4'h1, 4'h2);
    hold(4'hE, 8'h00, 4); hold(4'hD, 8'hFF, 4); hold(4'hB, 8'hB0, 4); hold(4'h7, 8'h99, 4);
    hold(4'hF, 8'hFF, 6);

    // Multiple / no anodes low are ignored; mask only fills on the later E.
    hold(4'hC, 8'hF9, 10); hold(4'hF, 8'hF9, 10);
    hold(4'hD, 8'hA4, 4); hold(4'hB, 8'hB0, 4); hold(4'h7, 8'h99, 4);
    hold(4'hF, 8'hFF, 6);
    check("no_frame_multi_anode", 32'(exp_q.size()), 32'd0);
    push(16'h4321, 4'h0, 4'h0);
    hold(4'hE, 8'hF9, 4);
    hold(4'hF, 8'hFF, 6);

    // Repeat capture of digit 0 overwrites its slot.
    push(16'h4320, 4'h0, 4'h0);
    hold(4'hE, 8'hF9, 4); hold(4'hD, 8'hA4, 4); hold(4'hE, 8'hC0, 4);
    hold(4'hB, 8'hB0, 4); hold(4'h7, 8'h99, 4);
    hold(4'hF, 8'hFF, 20);
    check("stale_after_idle", 32'(stale), 32'd1);

    // Reset mid-frame: outputs clear at once, partial mask discarded.
    hold(4'hE, 8'hF9, 4); hold(4'hD, 8'hA4, 4); hold(4'hB, 8'hB0, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_digits", 32'(digits), 32'd0);
    check("midrst_dp", 32'(dp_out), 32'd0);
    check("midrst_err", 32'(digit_err), 32'd0);
    check("midrst_stale", 32'(stale), 32'd0);
    check("midrst_fv", 32'(frame_valid), 32'd0);
    an = 4'hF; seg = 8'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(4'h7, 8'h99, 4);
    hold(4'hF, 8'hFF, 10);
    check("no_frame_after_rst", 32'(exp_q.size()), 32'd0);
    push(16'h4321, 4'h0, 4'h0);
    hold(4'hE, 8'hF9, 4); hold(4'hD, 8'hA4, 4); hold(4'hB, 8'hB0, 4);
    hold(4'hF, 8'hFF, 8);

    check("all_frames_seen", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
